// File: rtl/lc3b_muldiv_unit.sv
// Purpose: iterative radix-2 multiply (shift-add) / restoring divide, signed or unsigned, for the EX stage.
// Latency: fixed WIDTH+2 cycles from accepted start to the one-cycle done pulse, for every op.
// Backpressure: busy=1 during CALC/FIX; start is dropped while busy, flush aborts to IDLE.
// Ports: clk/reset_n (async active-low); start, op (00 umul, 01 smul, 10 udiv, 11 sdiv), flush,
//        operand_a (multiplicand/dividend), operand_b (multiplier/divisor) in;
//        busy, done, result_lo (product low / quotient), result_hi (product high / remainder), div_by_zero out.
module lc3b_muldiv_unit #(
  parameter int WIDTH          = 16,
  parameter bit SIGNED_SUPPORT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_res;   // quotient / product must be negated
  logic             neg_rem;   // remainder takes the dividend sign
  logic             dbz;
  // acc: product high half / partial remainder. lo_reg: multiplier / dividend shifting into quotient.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] raw_a;     // unmodified dividend, returned as remainder on divide by zero

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;

  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

  always_comb begin
    signed_op = SIGNED_SUPPORT && op[0];
    a_neg     = signed_op && operand_a[WIDTH-1];
    b_neg     = signed_op && operand_b[WIDTH-1];
    a_mag     = a_neg ? -operand_a : operand_a;
    b_mag     = b_neg ? -operand_b : operand_b;
    accept    = start && !flush && ((state == S_IDLE) || (state == S_DONE));
  end

  always_comb begin
    mul_addend = lo_reg[0] ? opnd : '0;
    mul_sum    = {1'b0, acc} + {1'b0, mul_addend};
    div_sh     = {acc, lo_reg[WIDTH-1]};
    div_ge     = (div_sh >= {1'b0, opnd});
    // When the trial subtract succeeds the true difference is below the divisor, so WIDTH bits suffice.
    div_diff   = div_sh[WIDTH-1:0] - opnd;
    prod       = {acc, lo_reg};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dbz         <= 1'b0;
      acc         <= '0;
      lo_reg      <= '0;
      opnd        <= '0;
      raw_a       <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state   <= S_CALC;
            cnt     <= CNT_LOAD;
            is_div  <= op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dbz     <= op[1] && (operand_b == '0);
            acc     <= '0;
            lo_reg  <= op[1] ? a_mag : b_mag;
            opnd    <= op[1] ? b_mag : a_mag;
            raw_a   <= operand_a;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (is_div) begin
              acc    <= div_ge ? div_diff : div_sh[WIDTH-1:0];
              lo_reg <= {lo_reg[WIDTH-2:0], div_ge};
            end else begin
              acc    <= mul_sum[WIDTH:1];
              lo_reg <= {mul_sum[0], lo_reg[WIDTH-1:1]};
            end
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            state       <= S_DONE;
            div_by_zero <= dbz;
            if (dbz) begin
              result_lo <= '1;
              result_hi <= raw_a;
            end else if (is_div) begin
              // MIN_INT / -1 needs no special case: both signs negative, magnitude wraps to MIN_INT.
              result_lo <= neg_res ? -lo_reg : lo_reg;
              result_hi <= neg_rem ? -acc : acc;
            end else begin
              {result_hi, result_lo} <= neg_res ? -prod : prod;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
